// File: rtl/pixel_decrypt.sv
// Receive-side pixel stream decryptor: Bernoulli-map keystream XORed onto each
// accepted pixel, reseeded from the loaded key at every unseeded start of frame.
module pixel_decrypt #(
  parameter int DATA_W = 24,
  parameter int WARMUP = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [79:0]       key_in,
  input  logic              key_load,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sof,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sof,
  output logic              keyed
);

  typedef enum logic [1:0] {ST_IDLE, ST_WARMUP, ST_RUN} state_t;

  localparam logic [79:0] BERN_HALF = 80'h4000_0000_0000_0000_0000;
  localparam logic [79:0] BERN_TOP  = 80'h8000_0000_0000_0000_0000;
  localparam logic [7:0]  WARMUP_N  = 8'(WARMUP);

  state_t              state_q, state_d;
  logic [79:0]         k0_q, k0_d;
  logic [79:0]         kr_q, kr_d;
  logic [79:0]         s_q, s_d;
  logic [7:0]          wcnt_q, wcnt_d;
  logic                seeded_q, seeded_d;
  logic                keyed_q, keyed_d;
  logic                ov_q, ov_d;
  logic [DATA_W-1:0]   od_q, od_d;
  logic                os_q, os_d;

  logic [79:0]         s_shift, s_step, kr_step;
  logic                reseed_req, out_free;

  // Doubling map folded into the upper half; the carry out of bit 79 is dropped.
  always_comb begin
    s_shift = {s_q[78:0], 1'b0};
    s_step  = ((s_q < BERN_HALF) ? s_shift : (s_shift + BERN_TOP)) ^ kr_q;
    kr_step = {kr_q[78:0], kr_q[79]};
  end

  assign reseed_req = in_valid && in_sof && !seeded_q;
  assign out_free   = !ov_q || out_ready;

  always_comb begin
    state_d  = state_q;
    k0_d     = k0_q;
    kr_d     = kr_q;
    s_d      = s_q;
    wcnt_d   = wcnt_q;
    seeded_d = seeded_q;
    keyed_d  = keyed_q;
    ov_d     = ov_q;
    od_d     = od_q;
    os_d     = os_q;
    in_ready = 1'b0;

    if (ov_q && out_ready) ov_d = 1'b0;

    case (state_q)
      ST_WARMUP: begin
        s_d    = s_step;
        kr_d   = kr_step;
        wcnt_d = wcnt_q - 8'd1;
        if (wcnt_q == 8'd1) begin
          seeded_d = 1'b1;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        in_ready = !reseed_req && out_free && !key_load;
        if (reseed_req) begin
          state_d = ST_WARMUP;
          s_d     = k0_q;
          kr_d    = k0_q;
          wcnt_d  = WARMUP_N;
        end else if (in_valid && in_ready) begin
          s_d      = s_step;
          kr_d     = kr_step;
          seeded_d = 1'b0;
          ov_d     = 1'b1;
          od_d     = in_data ^ s_q[79 -: DATA_W];
          os_d     = in_sof;
        end
      end
      default: ;
    endcase

    // A new key preempts everything, including a pending output word.
    if (key_load) begin
      k0_d    = key_in;
      keyed_d = 1'b1;
      ov_d    = 1'b0;
      state_d = ST_WARMUP;
      s_d     = key_in;
      kr_d    = key_in;
      wcnt_d  = WARMUP_N;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q  <= ST_IDLE;
      k0_q     <= '0;
      kr_q     <= '0;
      s_q      <= '0;
      wcnt_q   <= '0;
      seeded_q <= 1'b0;
      keyed_q  <= 1'b0;
      ov_q     <= 1'b0;
      od_q     <= '0;
      os_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      k0_q     <= k0_d;
      kr_q     <= kr_d;
      s_q      <= s_d;
      wcnt_q   <= wcnt_d;
      seeded_q <= seeded_d;
      keyed_q  <= keyed_d;
      ov_q     <= ov_d;
      od_q     <= od_d;
      os_q     <= os_d;
    end
  end

  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign out_sof   = os_q;
  assign keyed     = keyed_q;

endmodule

// File: tb/tb_pixel_decrypt.sv
// Randomized bench for pixel_decrypt: a per-cycle behavioural model predicts the
// handshake and decrypted words; a second instance pins the keystream by hand.
module tb_pixel_decrypt;

  localparam int DW = 24;
  localparam int WU = 8;

  logic          Clk = 1'b0;
  logic          Reset = 1'b0;
  logic [79:0]   key_in = '0;
  logic          key_load = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          in_sof = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          out_sof;
  logic          keyed;

  logic [79:0]   b_key = '0;
  logic          b_load = 1'b0;
  logic          b_valid = 1'b0;
  logic          b_ready;
  logic [DW-1:0] b_data = '0;
  logic          b_ovalid;
  logic [DW-1:0] b_odata;
  logic          b_osof;
  logic          b_keyed;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;
  int ready_mode = 0;  // 0: always ready, 1: random, 2: stalled

  pixel_decrypt #(.DATA_W(DW), .WARMUP(WU)) dut (
    .Clk(Clk), .Reset(Reset), .key_in(key_in), .key_load(key_load),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sof(in_sof),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sof(out_sof), .keyed(keyed));

  pixel_decrypt #(.DATA_W(DW), .WARMUP(1)) dut_w1 (
    .Clk(Clk), .Reset(Reset), .key_in(b_key), .key_load(b_load),
    .in_valid(b_valid), .in_ready(b_ready), .in_data(b_data), .in_sof(1'b0),
    .out_valid(b_ovalid), .out_ready(1'b1), .out_data(b_odata),
    .out_sof(b_osof), .keyed(b_keyed));

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Generator state after n steps from seed: S starts at key, the step XOR operand
  // is the key rotated left by the step index.
  function automatic logic [79:0] gen_state(input logic [79:0] key, input int n);
    logic [79:0] s, kr;
    int r;
    s = key;
    for (int i = 0; i < n; i++) begin
      r  = i % 80;
      kr = (r == 0) ? key : ((key << r) | (key >> (80 - r)));
      s  = (s * 80'd2 + ((s >= 80'h4000_0000_0000_0000_0000) ? 80'h8000_0000_0000_0000_0000 : 80'd0)) ^ kr;
    end
    return s;
  endfunction

  logic [79:0]   m_k0 = '0;
  bit            m_keyed = 0, m_run = 0, m_seeded = 0, m_ov = 0, m_os = 0;
  int            m_warm = 0, m_n = 0;
  logic [DW-1:0] m_od = '0;
  logic [79:0]   m_s;
  bit            exp_ready;

  always @(negedge Clk) begin
    exp_ready = m_run && !key_load && !(in_valid && in_sof && !m_seeded) && (!m_ov || out_ready);
    if (chk_en) begin
      chk("in_ready", 80'(in_ready), 80'(exp_ready));
      chk("out_valid", 80'(out_valid), 80'(m_ov));
      chk("keyed", 80'(keyed), 80'(m_keyed));
      if (m_ov) begin
        chk("out_data", 80'(out_data), 80'(m_od));
        chk("out_sof", 80'(out_sof), 80'(m_os));
      end
    end
    if (!Reset) begin
      m_k0 = '0; m_keyed = 0; m_run = 0; m_seeded = 0; m_ov = 0;
      m_od = '0; m_os = 0; m_warm = 0; m_n = 0;
    end else if (key_load) begin
      m_k0 = key_in; m_keyed = 1; m_ov = 0; m_run = 0; m_warm = WU; m_n = 0;
    end else if (m_warm > 0) begin
      m_n++; m_warm--;
      if (m_warm == 0) begin m_run = 1; m_seeded = 1; end
      if (m_ov && out_ready) m_ov = 0;
    end else if (m_run && in_valid && in_sof && !m_seeded) begin
      m_run = 0; m_warm = WU; m_n = 0;
      if (m_ov && out_ready) m_ov = 0;
    end else if (exp_ready && in_valid) begin
      m_s = gen_state(m_k0, m_n);
      m_od = in_data ^ m_s[79 -: DW];
      m_os = in_sof; m_ov = 1; m_seeded = 0; m_n++;
    end else if (m_ov && out_ready) begin
      m_ov = 0;
    end
  end

  initial begin
    forever begin
      @(posedge Clk); #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic drive_pixel(input logic [DW-1:0] d, input logic s);
    bit done;
    done = 0;
    in_valid = 1'b1; in_data = d; in_sof = s;
    for (int c = 0; c < 80 && !done; c++) begin
      @(negedge Clk);
      if (in_ready) begin @(posedge Clk); #1; done = 1; end
    end
    in_valid = 1'b0; in_sof = 1'b0;
    if (!done) begin
      chk("accept_timeout", 80'd0, 80'd1);
      @(posedge Clk); #1;
    end
  endtask

  task automatic pulse_key(input logic [79:0] k);
    key_in = k; key_load = 1'b1;
    @(posedge Clk); #1;
    key_load = 1'b0;
  endtask

  logic [DW-1:0] frame [100];
  logic [DW-1:0] gen_exp [3];
  int cnt;

  initial begin
    repeat (2) @(posedge Clk);
    #1;
    chk_en = 1'b1;
    Reset = 1'b1;
    chk("rst_keyed", 80'(keyed), 80'd0);
    chk("rst_out_valid", 80'(out_valid), 80'd0);
    chk("rst_out_data", 80'(out_data), 80'd0);
    chk("rst_out_sof", 80'(out_sof), 80'd0);
    chk("rst_in_ready", 80'(in_ready), 80'd0);

    // Keystream pinned by hand for WARMUP=1 and key 0x4000...
    gen_exp[0] = 24'h400000; gen_exp[1] = 24'h800000; gen_exp[2] = 24'h800000;
    b_key = 80'h4000_0000_0000_0000_0000; b_load = 1'b1;
    @(posedge Clk); #1;
    b_load = 1'b0;
    cnt = 0;
    while (!b_ready && cnt < 10) begin @(posedge Clk); #1; cnt++; end
    chk("gen_ready_seen", 80'(b_ready), 80'd1);
    b_valid = 1'b1; b_data = '0;
    for (int k = 0; k < 3; k++) begin
      @(posedge Clk); #1;
      chk("gen_out_valid", 80'(b_ovalid), 80'd1);
      chk("gen_out_data", 80'(b_odata), 80'(gen_exp[k]));
    end
    b_valid = 1'b0;

    // Zero key: identity keystream and first in_ready 9 cycles after key_load.
    key_in = '0; key_load = 1'b1;
    cnt = 0;
    @(posedge Clk); #1; cnt++;
    key_load = 1'b0;
    while (!in_ready && cnt < 20) begin @(posedge Clk); #1; cnt++; end
    chk("first_ready_cycle", 80'(cnt), 80'd9);
    drive_pixel(24'hABCDEF, 1'b0);
    chk("zero_key_px0", 80'(out_data), 80'h0000_0000_0000_00AB_CDEF);
    drive_pixel(24'h123456, 1'b0);
    chk("zero_key_px1", 80'(out_data), 80'h0000_0000_0000_0012_3456);

    // Two identical frames with a random key, backpressure in frame 1.
    for (int i = 0; i < 100; i++) frame[i] = DW'($urandom);
    pulse_key({$urandom, $urandom, 16'($urandom)});
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 100; i++) begin
        if (f == 0 && i == 50) begin
          ready_mode = 2;
          fork begin repeat (5) @(posedge Clk); ready_mode = 0; end join_none
        end
        drive_pixel(frame[i], i == 0);
      end
    end

    // key_load while a word is pending and a pixel is offered.
    ready_mode = 2;
    drive_pixel(DW'($urandom), 1'b0);
    chk("pending_before_key", 80'(out_valid), 80'd1);
    in_valid = 1'b1; in_data = DW'($urandom);
    pulse_key({$urandom, $urandom, 16'($urandom)});
    in_valid = 1'b0;
    chk("pending_dropped", 80'(out_valid), 80'd0);
    ready_mode = 0;
    for (int i = 0; i < 6; i++) drive_pixel(DW'($urandom), i == 0);

    // Random traffic with sporadic sof, key reloads and backpressure.
    ready_mode = 1;
    for (int c = 0; c < 1500; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = DW'($urandom);
      in_sof   = ($urandom_range(0, 29) == 0);
      key_in   = {$urandom, $urandom, 16'($urandom)};
      key_load = ($urandom_range(0, 249) == 0);
      @(posedge Clk); #1;
    end
    in_valid = 1'b0; in_sof = 1'b0; key_load = 1'b0;
    ready_mode = 0;

    // Reset during warm-up.
    pulse_key({$urandom, $urandom, 16'($urandom)});
    repeat (3) @(posedge Clk);
    #1;
    Reset = 1'b0;
    @(posedge Clk); #1;
    Reset = 1'b1;
    chk("rst_warm_keyed", 80'(keyed), 80'd0);
    chk("rst_warm_out_valid", 80'(out_valid), 80'd0);
    in_valid = 1'b1; in_sof = 1'b1;
    repeat (15) @(posedge Clk);
    #1;
    in_valid = 1'b0; in_sof = 1'b0;

    // Reset during run with a word pending.
    pulse_key({$urandom, $urandom, 16'($urandom)});
    ready_mode = 2;
    drive_pixel(DW'($urandom), 1'b1);
    Reset = 1'b0;
    @(posedge Clk); #1;
    Reset = 1'b1;
    ready_mode = 0;
    chk("rst_run_keyed", 80'(keyed), 80'd0);
    chk("rst_run_out_valid", 80'(out_valid), 80'd0);
    chk("rst_run_out_data", 80'(out_data), 80'd0);
    repeat (5) @(posedge Clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
